// File: rtl/exec_core.sv
// rtl/exec_core.sv - single-cycle 8-bit execution core: regfile, ALU, shifter, data memory, decode (optional SHIFT_UNIT_EN)
module exec_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] in,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic        Z,
  output logic        C
);

  typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_SHF} res_sel_e;

  logic [7:0] regs_q [8];
  logic [7:0] mem_q  [256];
  logic       z_q, z_d;
  logic       c_q, c_d;

  logic [2:0] rd, rs, rt;
  logic [7:0] imm;
  logic [7:0] a_val, p2_val, b_val;
  logic [2:0] p2_addr;
  logic       reg_we, mem_we, is_stm;
  res_sel_e   res_sel;
  logic [7:0] mem_addr;
  logic [7:0] alu_res, shf_res, wdata;
  logic       alu_c, shf_c;
  logic [8:0] wide;

  assign rd  = in[13:11];
  assign rs  = in[10:8];
  assign rt  = in[7:5];
  assign imm = in[7:0];

  assign dbg_data = regs_q[dbg_addr];
  assign Z        = z_q;
  assign C        = c_q;

  // Decode: write enables, second read-port select and result mux select, all from the instruction alone
  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    is_stm  = 1'b0;
    res_sel = SEL_ALU;
    if (in == 19'd0) begin
      reg_we = 1'b0;
    end else if (!in[18]) begin
      reg_we  = 1'b1;
      res_sel = SEL_ALU;
    end else if (in[17:16] == 2'b00) begin
      if (!in[15]) begin
        is_stm  = in[14];
        mem_we  = in[14];
        reg_we  = !in[14];
        res_sel = SEL_MEM;
      end
    end else if (in[17:16] == 2'b10) begin
`ifdef SHIFT_UNIT_EN
      reg_we  = 1'b1;
      res_sel = SEL_SHF;
`endif
    end
  end

  // Operand fetch and memory address; STM reads its store data through the second port using rd
  always_comb begin
    p2_addr  = is_stm ? rd : rt;
    a_val    = regs_q[rs];
    p2_val   = regs_q[p2_addr];
    b_val    = in[17] ? imm : p2_val;
    mem_addr = a_val + imm;
  end

  // ALU: 9-bit arithmetic so bit 8 is carry for add and borrow for subtract
  always_comb begin
    wide    = 9'd0;
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (in[16:14])
      3'b000: wide = {1'b0, a_val} + {1'b0, b_val};
      3'b001: wide = {1'b0, a_val} + {1'b0, b_val} + {8'd0, c_q};
      3'b010: wide = {1'b0, a_val} - {1'b0, b_val};
      3'b011: wide = {1'b0, a_val} - {1'b0, b_val} - {8'd0, c_q};
      3'b100: wide = {1'b0, a_val & b_val};
      3'b101: wide = {1'b0, a_val | b_val};
      3'b110: wide = {1'b0, a_val ^ b_val};
      default: wide = {1'b0, a_val & ~b_val};
    endcase
    alu_res = wide[7:0];
    alu_c   = in[16] ? 1'b0 : wide[8];
  end

  // Barrel shifter: carry is the last bit pushed out, zero for a zero amount
  always_comb begin
    shf_res = a_val;
    shf_c   = 1'b0;
`ifdef SHIFT_UNIT_EN
    case (in[15:14])
      2'b00: begin
        shf_res = a_val << rt;
        shf_c   = (rt == 3'd0) ? 1'b0 : a_val[3'd0 - rt];
      end
      2'b01: begin
        shf_res = a_val >> rt;
        shf_c   = (rt == 3'd0) ? 1'b0 : a_val[rt - 3'd1];
      end
      2'b10: begin
        shf_res = (a_val << rt) | (a_val >> ({1'b0, 3'd0 - rt}));
        shf_c   = (rt == 3'd0) ? 1'b0 : shf_res[0];
        if (rt == 3'd0) shf_res = a_val;
      end
      default: begin
        shf_res = (a_val >> rt) | (a_val << ({1'b0, 3'd0 - rt}));
        shf_c   = (rt == 3'd0) ? 1'b0 : shf_res[7];
        if (rt == 3'd0) shf_res = a_val;
      end
    endcase
`endif
  end

  // Write-back data and next flags; NOP clears flags, memory and no-op opcodes hold them
  always_comb begin
    wdata = alu_res;
    z_d   = z_q;
    c_d   = c_q;
    case (res_sel)
      SEL_MEM: wdata = mem_q[mem_addr];
      SEL_SHF: wdata = shf_res;
      default: wdata = alu_res;
    endcase
    if (in == 19'd0) begin
      z_d = 1'b0;
      c_d = 1'b0;
    end else if (reg_we && res_sel == SEL_ALU) begin
      z_d = (alu_res == 8'h00);
      c_d = alu_c;
    end else if (reg_we && res_sel == SEL_SHF) begin
      z_d = (shf_res == 8'h00);
      c_d = shf_c;
    end
  end

  // State update: reset clears everything and suppresses any write in that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: 8'h00};
      mem_q  <= '{default: 8'h00};
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      if (reg_we) regs_q[rd] <= wdata;
      if (mem_we) mem_q[mem_addr] <= p2_val;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - directed self-checking bench for exec_core
module tb_exec_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] in = 19'd0;
  logic [2:0]  dbg_addr = 3'd0;
  logic [7:0]  dbg_data;
  logic        Z, C;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [18:0] IDLE = {3'b101, 16'h0000};

  exec_core dut (
    .clk(clk), .rst(rst), .in(in), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .Z(Z), .C(C)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] alu_i(input logic [2:0] op, input logic [2:0] rd_f,
                                        input logic [2:0] rs_f, input logic [7:0] imm_f);
    return {1'b0, 1'b1, op, rd_f, rs_f, imm_f};
  endfunction

  function automatic logic [18:0] alu_r(input logic [2:0] op, input logic [2:0] rd_f,
                                        input logic [2:0] rs_f, input logic [2:0] rt_f);
    return {1'b0, 1'b0, op, rd_f, rs_f, rt_f, 5'b0};
  endfunction

  function automatic logic [18:0] mem_i(input logic [1:0] kind, input logic [2:0] rd_f,
                                        input logic [2:0] rs_f, input logic [7:0] imm_f);
    return {3'b100, kind, rd_f, rs_f, imm_f};
  endfunction

  function automatic logic [18:0] shf_i(input logic [1:0] kind, input logic [2:0] rd_f,
                                        input logic [2:0] rs_f, input logic [2:0] amt);
    return {3'b110, kind, rd_f, rs_f, amt, 5'b0};
  endfunction

  task automatic exec(input logic [18:0] instr);
    @(negedge clk);
    in = instr;
    @(posedge clk);
    #1;
    in = IDLE;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in  = alu_i(3'b000, 3'd1, 3'd0, 8'h55);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    in  = IDLE;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0]; #0.1;
      n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d got %h want 00", i, dbg_data); end
    end
    n_chk++; if (Z !== 1'b0) begin n_fail++; $display("FAIL reset_z got %b want 0", Z); end
    n_chk++; if (C !== 1'b0) begin n_fail++; $display("FAIL reset_c got %b want 0", C); end
  endtask

  task automatic test_add;
    exec(alu_i(3'b000, 3'd1, 3'd0, 8'hF0));
    exec(alu_i(3'b000, 3'd2, 3'd0, 8'h20));
    exec(alu_r(3'b000, 3'd3, 3'd1, 3'd2));
    dbg_addr = 3'd3; #0.1;
    n_chk++; if (dbg_data !== 8'h10) begin n_fail++; $display("FAIL add_r3 got %h want 10", dbg_data); end
    n_chk++; if (C !== 1'b1 || Z !== 1'b0) begin n_fail++; $display("FAIL add_flags got Z%b C%b want Z0 C1", Z, C); end
    exec(alu_i(3'b001, 3'd4, 3'd0, 8'h00));
    dbg_addr = 3'd4; #0.1;
    n_chk++; if (dbg_data !== 8'h01) begin n_fail++; $display("FAIL adc_r4 got %h want 01", dbg_data); end
    n_chk++; if (C !== 1'b0 || Z !== 1'b0) begin n_fail++; $display("FAIL adc_flags got Z%b C%b want Z0 C0", Z, C); end
  endtask

  task automatic test_sub;
    exec(alu_r(3'b010, 3'd5, 3'd2, 3'd2));
    dbg_addr = 3'd5; #0.1;
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL sub0_r5 got %h want 00", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b0) begin n_fail++; $display("FAIL sub0_flags got Z%b C%b want Z1 C0", Z, C); end
    exec(alu_r(3'b010, 3'd5, 3'd2, 3'd1));
    dbg_addr = 3'd5; #0.1;
    n_chk++; if (dbg_data !== 8'h30) begin n_fail++; $display("FAIL sub_r5 got %h want 30", dbg_data); end
    n_chk++; if (C !== 1'b1 || Z !== 1'b0) begin n_fail++; $display("FAIL sub_flags got Z%b C%b want Z0 C1", Z, C); end
    // 0x20 - 0x1F - 1 = 0 with no borrow
    exec(alu_i(3'b011, 3'd7, 3'd2, 8'h1F));
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL sbc_r7 got %h want 00", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b0) begin n_fail++; $display("FAIL sbc_flags got Z%b C%b want Z1 C0", Z, C); end
  endtask

  task automatic test_logic;
    exec(alu_i(3'b111, 3'd7, 3'd1, 8'h30));
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'hC0) begin n_fail++; $display("FAIL andn_r7 got %h want c0", dbg_data); end
    exec(alu_r(3'b110, 3'd7, 3'd7, 3'd1));
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'h30) begin n_fail++; $display("FAIL xor_r7 got %h want 30", dbg_data); end
    exec(alu_i(3'b101, 3'd7, 3'd7, 8'h0C));
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'h3C) begin n_fail++; $display("FAIL or_r7 got %h want 3c", dbg_data); end
    n_chk++; if (Z !== 1'b0 || C !== 1'b0) begin n_fail++; $display("FAIL logic_flags got Z%b C%b want Z0 C0", Z, C); end
  endtask

  task automatic test_mem;
    exec(alu_r(3'b000, 3'd7, 3'd1, 3'd3));  // 0xF0 + 0x10 -> 0x00, Z1 C1
    exec(mem_i(2'b01, 3'd1, 3'd2, 8'h05));
    n_chk++; if (Z !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL stm_flags got Z%b C%b want Z1 C1", Z, C); end
    exec(mem_i(2'b00, 3'd6, 3'd0, 8'h25));
    dbg_addr = 3'd6; #0.1;
    n_chk++; if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL ldm_r6 got %h want f0", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL ldm_flags got Z%b C%b want Z1 C1", Z, C); end
    exec(mem_i(2'b00, 3'd5, 3'd1, 8'h35));  // 0xF0 + 0x35 wraps to 0x25
    dbg_addr = 3'd5; #0.1;
    n_chk++; if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL ldm_wrap_r5 got %h want f0", dbg_data); end
    exec(mem_i(2'b10, 3'd5, 3'd0, 8'h00));  // in[15]=1: no effect
    dbg_addr = 3'd5; #0.1;
    n_chk++; if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL mem_noop_r5 got %h want f0", dbg_data); end
  endtask

  task automatic test_shift;
    exec(shf_i(2'b00, 3'd1, 3'd1, 3'd4));
    dbg_addr = 3'd1; #0.1;
`ifdef SHIFT_UNIT_EN
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL shl_r1 got %h want 00", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL shl_flags got Z%b C%b want Z1 C1", Z, C); end
    exec(alu_i(3'b000, 3'd7, 3'd0, 8'h81));
    exec(shf_i(2'b11, 3'd7, 3'd7, 3'd1));
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'hC0) begin n_fail++; $display("FAIL ror_r7 got %h want c0", dbg_data); end
    n_chk++; if (C !== 1'b1 || Z !== 1'b0) begin n_fail++; $display("FAIL ror_flags got Z%b C%b want Z0 C1", Z, C); end
    exec(shf_i(2'b10, 3'd6, 3'd7, 3'd0));
    dbg_addr = 3'd6; #0.1;
    n_chk++; if (dbg_data !== 8'hC0) begin n_fail++; $display("FAIL rol0_r6 got %h want c0", dbg_data); end
    n_chk++; if (C !== 1'b0) begin n_fail++; $display("FAIL rol0_c got %b want 0", C); end
    exec(shf_i(2'b01, 3'd6, 3'd7, 3'd7));
    dbg_addr = 3'd6; #0.1;
    n_chk++; if (dbg_data !== 8'h01 || C !== 1'b1) begin n_fail++; $display("FAIL shr7 got %h C%b want 01 C1", dbg_data, C); end
    exec(alu_i(3'b000, 3'd1, 3'd0, 8'hF0));
`else
    n_chk++; if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL shf_off_r1 got %h want f0", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL shf_off_flags got Z%b C%b want Z1 C1", Z, C); end
`endif
  endtask

  task automatic test_nop_branch;
    exec(alu_i(3'b000, 3'd7, 3'd0, 8'hFF));
    exec(alu_i(3'b000, 3'd7, 3'd7, 8'h01));  // 0xFF + 1 -> 0x00, Z1 C1
    exec({3'b101, 16'hFFFF});
    exec({3'b111, 16'hFFFF});
    dbg_addr = 3'd7; #0.1;
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL branch_r7 got %h want 00", dbg_data); end
    n_chk++; if (Z !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL branch_flags got Z%b C%b want Z1 C1", Z, C); end
    exec(19'd0);
    n_chk++; if (Z !== 1'b0 || C !== 1'b0) begin n_fail++; $display("FAIL nop_flags got Z%b C%b want Z0 C0", Z, C); end
    dbg_addr = 3'd0; #0.1;
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL nop_r0 got %h want 00", dbg_data); end
  endtask

  task automatic test_back_to_back;
    exec(alu_i(3'b000, 3'd3, 3'd0, 8'h05));
    exec(alu_r(3'b000, 3'd3, 3'd3, 3'd3));
    exec(mem_i(2'b01, 3'd3, 3'd0, 8'hFF));
    exec(mem_i(2'b00, 3'd3, 3'd0, 8'h25));
    exec(mem_i(2'b00, 3'd4, 3'd0, 8'hFF));
    dbg_addr = 3'd3; #0.1;
    n_chk++; if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL b2b_ld_r3 got %h want f0", dbg_data); end
    dbg_addr = 3'd4; #0.1;
    n_chk++; if (dbg_data !== 8'h0A) begin n_fail++; $display("FAIL b2b_st_r4 got %h want 0a", dbg_data); end
  endtask

  task automatic test_reset_mid;
    exec(alu_r(3'b000, 3'd7, 3'd1, 3'd3));  // 0xF0 + 0xF0 -> carry set
    @(negedge clk);
    rst = 1'b1;
    in  = alu_i(3'b000, 3'd2, 3'd0, 8'h77);
    @(posedge clk); #1;
    rst = 1'b0;
    in  = IDLE;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0]; #0.1;
      n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL midrst_r%0d got %h want 00", i, dbg_data); end
    end
    n_chk++; if (Z !== 1'b0 || C !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got Z%b C%b want Z0 C0", Z, C); end
    exec(alu_i(3'b000, 3'd6, 3'd0, 8'h01));
    exec(mem_i(2'b00, 3'd6, 3'd0, 8'h25));
    dbg_addr = 3'd6; #0.1;
    n_chk++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL midrst_mem got %h want 00", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mem();
    test_shift();
    test_nop_branch();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
